disp_delay_ctrl: RTL

DISP_DELAY_CTRL -- requirements
Module: disp_delay_ctrl

---
 rtl/disp_pkg.sv | 21 ++
 rtl/disp_pos_cnt.sv | 43 ++++
 rtl/disp_delay_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared defaults, delay-line length helper and controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package disp_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int WIN_DEF   = 5;

  // Length of the external pixel delay line for a given line width and window.
  function automatic int calc_delay(input int img_w, input int win);
    return img_w * win + win;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/disp_pos_cnt.sv
// Raster position counter: col wraps at IMG_W-1 and then bumps row; last flags the final pixel.
// Latency: position advances on the edge after inc.
// Backpressure: none; counts whenever inc is high, clr has priority.
module disp_pos_cnt
  import disp_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic col_last;
  logic row_last;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign last     = col_last && row_last;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_delay_ctrl.sv
// Tracks pixel positions into and out of an external delay line; flags border pixels and frame end.
// Latency: o_col/o_row/o_border/o_frame_done/o_err are registered, one cycle after the causing input.
// Backpressure: none; optional FLUSH watchdog under DISP_DELAY_CTRL_WDOG_EN.
module disp_delay_ctrl
  import disp_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int WIN   = WIN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sof,
  input  logic       i_valid,
  input  logic       i_dly_valid,
  output logic [9:0] o_col,
  output logic [8:0] o_row,
  output logic       o_border,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LO = CW'(WIN);
  localparam logic [CW-1:0] COL_HI = CW'(IMG_W - 1 - WIN);
  localparam logic [RW-1:0] ROW_LO = RW'(WIN);
  localparam logic [RW-1:0] ROW_HI = RW'(IMG_H - 1 - WIN);

  state_t state, next_state;

  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic          in_last, out_last, in_zero;
  logic          in_inc, in_clr, out_inc, out_clr;
  logic          err_d, done_d, sof_v, border, wdog_fire;

  disp_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_in_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(in_clr), .inc(in_inc),
    .col(in_col), .row(in_row), .last(in_last)
  );

  disp_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_out_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(out_clr), .inc(out_inc),
    .col(out_col), .row(out_row), .last(out_last)
  );

  assign sof_v   = i_valid && i_sof;
  assign in_zero = (in_col == '0) && (in_row == '0);
  assign border  = (out_col < COL_LO) || (out_col > COL_HI) ||
                   (out_row < ROW_LO) || (out_row > ROW_HI);
  assign o_busy  = (state != ST_IDLE);

`ifdef DISP_DELAY_CTRL_WDOG_EN
  localparam int DELAY = calc_delay(IMG_W, WIN);
  localparam int WDW   = $clog2(DELAY + 17);
  logic [WDW-1:0] wdog_cnt;

  // Counts cycles spent in FLUSH; fires so the error lands DELAY+16 cycles after entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != ST_FLUSH) wdog_cnt <= '0;
    else                               wdog_cnt <= wdog_cnt + 1'b1;
  end
  assign wdog_fire = (state == ST_FLUSH) && (wdog_cnt == WDW'(DELAY + 15));
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_inc     = 1'b0;
    in_clr     = 1'b0;
    out_inc    = 1'b0;
    out_clr    = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_dly_valid) err_d = 1'b1;
        if (sof_v) begin
          next_state = ST_RUN;
          in_inc     = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          if (i_sof && !in_zero) begin
            err_d = 1'b1;
          end else begin
            in_inc = 1'b1;
            if (in_last) next_state = ST_FLUSH;
          end
        end
        if (i_dly_valid) begin
          out_inc = 1'b1;
          if (out_last) begin
            done_d     = 1'b1;
            next_state = ST_IDLE;
            in_clr     = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // A new frame's first pixel may ride on the cycle that retires the old one.
        if (i_dly_valid) begin
          out_inc = 1'b1;
          if (out_last) begin
            done_d     = 1'b1;
            next_state = sof_v ? ST_RUN : ST_IDLE;
            in_inc     = sof_v;
          end
        end
        if (sof_v && !(i_dly_valid && out_last)) err_d = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
    if (wdog_fire) begin
      err_d      = 1'b1;
      next_state = ST_IDLE;
      in_clr     = 1'b1;
      out_clr    = 1'b1;
      out_inc    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_col        <= '0;
      o_row        <= '0;
      o_border     <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_frame_done <= done_d;
      o_err        <= err_d;
      if (out_inc) begin
        o_col    <= 10'(out_col);
        o_row    <= 9'(out_row);
        o_border <= border;
      end
    end
  end

endmodule
